display_page_scheduler: RTL and testbench

//  Shares the single 4-digit 7-segment display between N_SRC 10-bit values
//  (e.g. duty count, period, dead-time, ADC reading).

---
 rtl/display_page_scheduler_pkg.sv | 27 ++
 rtl/display_tick_gen.sv | 29 ++
 rtl/display_page_scheduler.sv | 138 +++++++++++++
 tb/tb_display_page_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/display_page_scheduler_pkg.sv
// Shared definitions for the display page scheduler.
//   state_t      : scheduler FSM state encoding
//   DEF_*        : default timing constants for a 50 MHz clk (1 kHz tick)
//   lowest_set() : index of the lowest set bit of a 4-bit request vector
package display_page_scheduler_pkg;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_OVERRIDE = 1'b1
    } state_t;

    localparam int DEF_TICK_DIV   = 50000;
    localparam int DEF_HOLD_TICKS = 2000;
    localparam int DEF_OVR_TICKS  = 3000;
    localparam int PAGE_W         = 2;

    // Lowest index wins when several sources report a change together.
    function automatic logic [PAGE_W-1:0] lowest_set(input logic [3:0] req);
        logic [PAGE_W-1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) idx = PAGE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/display_tick_gen.sv
// Free-running tick generator.
//   clk   : system clock
//   reset : synchronous, active-high; clears the divider
//   tick  : one-cycle pulse every TICK_DIV clocks (when count == TICK_DIV-1)
module display_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick_cnt == LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/display_page_scheduler.sv
// Shares one 4-digit display between N_SRC values by selecting a page and
// presenting a tick-synchronous snapshot of that source.
//   clk        : system clock
//   reset      : synchronous, active-high
//   src_data   : packed sources, page p = src_data[p*W +: W]
//   src_req    : 1-cycle pulse per source, "show me now" (override)
//   auto_en    : 1 = rotate pages every HOLD_TICKS ticks
//   step       : 1-cycle pulse, advance to next page (NORMAL only)
//   number     : snapshot of the selected source
//   page       : current page index
//   page_oh    : one-hot copy of page
//   ovr_active : high while an override page is shown
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_NORMAL   | auto rotation / step pulses select the page
// ST_OVERRIDE | requested page held for OVR_TICKS ticks, then saved_page
module display_page_scheduler
    import display_page_scheduler_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int W          = 10,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int OVR_TICKS  = DEF_OVR_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC*W-1:0] src_data,
    input  logic [N_SRC-1:0]   src_req,
    input  logic               auto_en,
    input  logic               step,
    output logic [W-1:0]       number,
    output logic [1:0]         page,
    output logic [N_SRC-1:0]   page_oh,
    output logic               ovr_active
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int OW = (OVR_TICKS > 1) ? $clog2(OVR_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [OW-1:0] OVR_LAST  = OW'(OVR_TICKS - 1);
    localparam logic [1:0]    PAGE_LAST = 2'(N_SRC - 1);

    logic          tick;
    state_t        state, state_next;
    logic [1:0]    page_q, page_next, page_inc;
    logic [1:0]    saved_page, saved_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [OW-1:0] ovr_cnt, ovr_next;
    logic [W-1:0]  number_q;
    logic [N_SRC-1:0] page_oh_q, page_oh_d;
    logic          ovr_q, ovr_d;
    logic          snap_load;

    display_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign page_inc = (page_q == PAGE_LAST) ? 2'd0 : page_q + 2'd1;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_NORMAL;
            page_q     <= '0;
            saved_page <= '0;
            hold_cnt   <= '0;
            ovr_cnt    <= '0;
            number_q   <= '0;
            page_oh_q  <= N_SRC'(1);
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_next;
            page_q     <= page_next;
            saved_page <= saved_next;
            hold_cnt   <= hold_next;
            ovr_cnt    <= ovr_next;
            page_oh_q  <= page_oh_d;
            ovr_q      <= ovr_d;
            if (snap_load)
                number_q <= src_data[int'(page_next)*W +: W];
        end
    end

    // Next state; priority src_req > expiry > step > rotation
    always_comb begin
        state_next = state;
        page_next  = page_q;
        saved_next = saved_page;
        hold_next  = hold_cnt;
        ovr_next   = ovr_cnt;
        if (|src_req) begin
            // A restart inside OVERRIDE keeps the page we came from.
            if (state == ST_NORMAL) saved_next = page_q;
            page_next  = lowest_set(4'(src_req));
            ovr_next   = '0;
            state_next = ST_OVERRIDE;
        end else if (state == ST_OVERRIDE) begin
            if (tick) begin
                if (ovr_cnt == OVR_LAST) begin
                    page_next  = saved_page;
                    hold_next  = '0;
                    state_next = ST_NORMAL;
                end else begin
                    ovr_next = ovr_cnt + OW'(1);
                end
            end
        end else if (step) begin
            page_next = page_inc;
            hold_next = '0;
        end else if (!auto_en) begin
            hold_next = '0;
        end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
                page_next = page_inc;
                hold_next = '0;
            end else begin
                hold_next = hold_cnt + HW'(1);
            end
        end
    end

    // Output decode, registered alongside page
    always_comb begin
        snap_load = tick || (page_next != page_q);
        page_oh_d = N_SRC'(1) << page_next;
        ovr_d     = (state_next == ST_OVERRIDE);
    end

    assign number     = number_q;
    assign page       = page_q;
    assign page_oh    = page_oh_q;
    assign ovr_active = ovr_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
module tb_display_page_scheduler;

    localparam int N_SRC      = 4;
    localparam int W          = 10;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 3;
    localparam int OVR_TICKS  = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N_SRC*W-1:0] src_data = '0;
    logic [N_SRC-1:0]   src_req = '0;
    logic               auto_en = 1'b1;
    logic               step = 1'b0;
    logic [W-1:0]       number;
    logic [1:0]         page;
    logic [N_SRC-1:0]   page_oh;
    logic               ovr_active;

    always #5 clk = ~clk;

    display_page_scheduler #(
        .N_SRC(N_SRC), .W(W), .TICK_DIV(TICK_DIV),
        .HOLD_TICKS(HOLD_TICKS), .OVR_TICKS(OVR_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .src_req(src_req),
        .auto_en(auto_en), .step(step), .number(number), .page(page),
        .page_oh(page_oh), .ovr_active(ovr_active)
    );

    typedef struct {
        int pg;
        int num;
        int ovr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time since reset, page, remembered page, tick counters
    int m_cyc, m_page, m_saved, m_in_ovr, m_hold_ticks, m_ovr_ticks, m_num;
    int src_val[N_SRC];

    task automatic model_cycle(input bit r, input int req, input bit st, input bit au);
        bit tick_now;
        int np;
        if (r) begin
            m_cyc = 0; m_page = 0; m_saved = 0; m_in_ovr = 0;
            m_hold_ticks = 0; m_ovr_ticks = 0; m_num = 0;
            return;
        end
        tick_now = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        m_cyc++;
        np = m_page;
        if (req != 0) begin
            if (!m_in_ovr) m_saved = m_page;
            for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) np = i;
            m_in_ovr = 1;
            m_ovr_ticks = 0;
        end else if (m_in_ovr) begin
            if (tick_now) begin
                if (m_ovr_ticks + 1 == OVR_TICKS) begin
                    np = m_saved; m_in_ovr = 0; m_hold_ticks = 0;
                end else m_ovr_ticks++;
            end
        end else if (st) begin
            np = (m_page + 1) % N_SRC; m_hold_ticks = 0;
        end else if (!au) begin
            m_hold_ticks = 0;
        end else if (tick_now) begin
            m_hold_ticks++;
            if (m_hold_ticks == HOLD_TICKS) begin
                np = (m_page + 1) % N_SRC; m_hold_ticks = 0;
            end
        end
        if (tick_now || np != m_page) m_num = src_val[np];
        m_page = np;
    endtask

    task automatic drive(input bit r, input int req, input bit st, input bit au);
        exp_t e;
        @(negedge clk);
        reset   = r;
        src_req = N_SRC'(req);
        step    = st;
        auto_en = au;
        for (int i = 0; i < N_SRC; i++) src_data[i*W +: W] = W'(src_val[i]);
        model_cycle(r, req, st, au);
        e.pg = m_page; e.num = m_num; e.ovr = m_in_ovr;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit au);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, au);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare each one issued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("page",       32'(page),       32'(e.pg));
                check("page_oh",    32'(page_oh),    32'(1 << e.pg));
                check("ovr_active", 32'(ovr_active), 32'(e.ovr));
                check("number",     32'(number),     32'(e.num));
            end
        end
    end

    initial begin
        int au;
        for (int i = 0; i < N_SRC; i++) src_val[i] = 100 * (i + 1);
        m_cyc = 0; m_page = 0; m_saved = 0; m_in_ovr = 0;
        m_hold_ticks = 0; m_ovr_ticks = 0; m_num = 0;

        // Auto rotation through all pages and back to 0
        drive(1'b1, 0, 1'b0, 1'b1);
        drive(1'b1, 0, 1'b0, 1'b1);
        idle(52, 1'b1);

        // Manual stepping, no change without step
        drive(1'b1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 1'b1, 1'b0);
            idle(7, 1'b0);
        end
        idle(10, 1'b0);

        // Override from page 1, expiry back to 1
        drive(1'b1, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(3, 1'b0);
        drive(1'b0, 4'b1100, 1'b0, 1'b0);
        idle(25, 1'b0);

        // Restart inside override keeps original saved page
        drive(1'b0, 4'b1100, 1'b0, 1'b0);
        idle(12, 1'b0);
        drive(1'b0, 4'b0001, 1'b0, 1'b0);
        idle(30, 1'b0);

        // step and src_req together; reset mid-override
        drive(1'b0, 4'b0010, 1'b1, 1'b0);
        idle(5, 1'b0);
        drive(1'b0, 4'b0100, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Source change between ticks is invisible until next tick
        idle(1, 1'b0);
        src_val[0] = 777;
        idle(8, 1'b0);
        src_val[0] = 1023;
        idle(8, 1'b0);

        // Randomized traffic
        au = 1;
        for (int n = 0; n < 3000; n++) begin
            int req;
            bit r, st;
            r   = ($urandom_range(0, 199) == 0);
            req = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 15)) : 0;
            st  = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 99) == 0) au = 1 - au;
            if ($urandom_range(0, 9) == 0)
                src_val[$urandom_range(0, N_SRC - 1)] = int'($urandom_range(0, 1023));
            drive(r, req, st, au[0]);
        end

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
